io_bus_arbiter: RTL and testbench

Shares the single IO peripheral bus between the CPU datapath's IO port and a debug/loader port. It sequences each access as a multi-cycle request/acknowledge transaction with a bounded wait. It stalls the CPU, via PC hold, until its transaction completes. It sits between the datapath's address-decoder IO outputs and the peripheral bus.

---
 rtl/io_arb_pkg.sv | 21 ++
 rtl/rr_arbiter2.sv | 23 ++
 rtl/io_bus_arbiter.sv | 156 +++++++++++++++
 tb/tb_io_bus_arbiter.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_arb_pkg.sv
// Shared types and constants for the IO peripheral bus arbiter.
package io_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_DONE = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DBG = 1'b1
  } owner_e;

  // Bit positions inside the one-hot grant vector.
  localparam int unsigned GNT_CPU = 0;
  localparam int unsigned GNT_DBG = 1;

  localparam logic [31:0] IO_ERR_DATA = 32'hFFFF_FFFF;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter; a tie goes to whoever did not win last.
module rr_arbiter2
  import io_arb_pkg::*;
(
  input  logic       req_cpu,
  input  logic       req_dbg,
  input  owner_e     last_grant,
  output logic [1:0] grant_c
);

  always_comb begin
    grant_c = 2'b00;
    if (req_cpu && req_dbg) begin
      if (last_grant == OWN_DBG) grant_c[GNT_CPU] = 1'b1;
      else                       grant_c[GNT_DBG] = 1'b1;
    end else if (req_cpu) begin
      grant_c[GNT_CPU] = 1'b1;
    end else if (req_dbg) begin
      grant_c[GNT_DBG] = 1'b1;
    end
  end

endmodule

// File: rtl/io_bus_arbiter.sv
// Shares one IO peripheral bus between the CPU IO port and a debug/loader port,
// running each access as a req/ack transaction with a bounded wait.
module io_bus_arbiter
  import io_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_ack,
  output logic              p_req,
  output logic              p_we,
  output logic [ADDR_W-1:0] p_addr,
  output logic [DATA_W-1:0] p_wdata,
  input  logic [DATA_W-1:0] p_rdata,
  input  logic              p_ack,
  output logic              bus_err
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_TC  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam int unsigned ERR_REP = (DATA_W + 31) / 32;
  localparam logic [DATA_W-1:0] ERR_DATA = DATA_W'({ERR_REP{IO_ERR_DATA}});

  arb_state_e        state_q, state_d;
  owner_e            owner_q, owner_d;
  owner_e            last_grant_q, last_grant_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              cpu_done_q, cpu_done_d;
  logic              dbg_ack_d, bus_err_d;
  logic              p_req_d, p_we_d;
  logic [ADDR_W-1:0] p_addr_d;
  logic [DATA_W-1:0] p_wdata_d;
  logic [1:0]        grant_c;

  rr_arbiter2 u_rr (
    .req_cpu    (cpu_req),
    .req_dbg    (dbg_req),
    .last_grant (last_grant_q),
    .grant_c    (grant_c)
  );

  // The CPU is released in the DONE cycle of its own transaction.
  assign cpu_stall = cpu_req & ~cpu_done_q;
  assign cpu_rdata = rdata_q;
  assign dbg_rdata = rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ARB_IDLE;
      owner_q      <= OWN_CPU;
      last_grant_q <= OWN_DBG;
      cnt_q        <= '0;
      rdata_q      <= '0;
      cpu_done_q   <= 1'b0;
      dbg_ack      <= 1'b0;
      bus_err      <= 1'b0;
      p_req        <= 1'b0;
      p_we         <= 1'b0;
      p_addr       <= '0;
      p_wdata      <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      rdata_q      <= rdata_d;
      cpu_done_q   <= cpu_done_d;
      dbg_ack      <= dbg_ack_d;
      bus_err      <= bus_err_d;
      p_req        <= p_req_d;
      p_we         <= p_we_d;
      p_addr       <= p_addr_d;
      p_wdata      <= p_wdata_d;
    end
  end

  // Next-state and next-output logic; completion flags are raised on entry to DONE.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    rdata_d      = rdata_q;
    cpu_done_d   = 1'b0;
    dbg_ack_d    = 1'b0;
    bus_err_d    = 1'b0;
    p_req_d      = 1'b0;
    p_we_d       = p_we;
    p_addr_d     = p_addr;
    p_wdata_d    = p_wdata;

    unique case (state_q)
      ARB_IDLE: begin
        if (grant_c[GNT_CPU]) begin
          owner_d   = OWN_CPU;
          p_we_d    = cpu_we;
          p_addr_d  = cpu_addr;
          p_wdata_d = cpu_wdata;
        end else if (grant_c[GNT_DBG]) begin
          owner_d   = OWN_DBG;
          p_we_d    = dbg_we;
          p_addr_d  = dbg_addr;
          p_wdata_d = dbg_wdata;
        end
        if (|grant_c) begin
          p_req_d = 1'b1;
          cnt_d   = '0;
          state_d = ARB_REQ;
        end
      end

      ARB_REQ: begin
        p_req_d = 1'b1;
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
        if (p_ack) begin
          if (!p_we) rdata_d = p_rdata;
          p_req_d    = 1'b0;
          cpu_done_d = (owner_q == OWN_CPU);
          dbg_ack_d  = (owner_q == OWN_DBG);
          state_d    = ARB_DONE;
        end else if (cnt_q >= CNT_TC) begin
          rdata_d    = ERR_DATA;
          bus_err_d  = 1'b1;
          p_req_d    = 1'b0;
          cpu_done_d = (owner_q == OWN_CPU);
          dbg_ack_d  = (owner_q == OWN_DBG);
          state_d    = ARB_DONE;
        end
      end

      ARB_DONE: begin
        last_grant_d = owner_q;
        state_d      = ARB_IDLE;
      end

      default: state_d = ARB_IDLE;
    endcase
  end

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Randomized self-checking bench for io_bus_arbiter with a transaction-level model.
module tb_io_bus_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int TMO = 15;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cpu_req, cpu_we, dbg_req, dbg_we;
  logic [AW-1:0] cpu_addr, dbg_addr, p_addr;
  logic [DW-1:0] cpu_wdata, dbg_wdata, cpu_rdata, dbg_rdata, p_wdata, p_rdata;
  logic          cpu_stall, dbg_ack, p_req, p_we, p_ack, bus_err;

  int vectors = 0;
  int miscompares = 0;

  // Peripheral responder settings and transaction-level model state.
  int            ack_delay = 0;
  logic [DW-1:0] ack_rdata = '0;
  bit            noise_en = 1'b0;
  logic [DW-1:0] m_rdata = '0;
  int            m_last = 1;  // 0 = CPU, 1 = DBG

  io_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
    .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
    .p_rdata(p_rdata), .p_ack(p_ack), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  // Peripheral: acks after ack_delay wait cycles (negative = never); noise outside REQ.
  initial begin
    int wcnt;
    wcnt = 0;
    p_ack = 1'b0;
    p_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (p_req) begin
        p_ack   = (ack_delay >= 0) && (wcnt == ack_delay);
        p_rdata = p_ack ? ack_rdata : DW'($urandom);
        wcnt++;
      end else begin
        wcnt    = 0;
        p_ack   = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
        p_rdata = DW'($urandom);
      end
    end
  end

  function automatic int exp_preq(input int d);
    return (d < 0 || d >= TMO) ? TMO : d + 1;
  endfunction

  function automatic bit exp_err(input int d);
    return (d < 0 || d >= TMO);
  endfunction

  function automatic logic [DW-1:0] exp_rdata(input logic [DW-1:0] prev, input bit we,
                                               input int d, input logic [DW-1:0] rv);
    if (exp_err(d)) return '1;
    return we ? prev : rv;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    cpu_req = 1'b0; dbg_req = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    m_rdata = '0;
    m_last = 1;
  endtask

  // Drives one transaction from one port; leaves the request asserted on return.
  task automatic run_txn(input bit is_dbg, input bit we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wd, input int d, input logic [DW-1:0] rv,
                         output int stall_n, output int preq_n, output logic [DW-1:0] rd,
                         output logic err, output bit latch_ok, output bit hung);
    bit done;
    ack_delay = d;
    ack_rdata = rv;
    if (is_dbg) begin
      dbg_we = we; dbg_addr = addr; dbg_wdata = wd; dbg_req = 1'b1;
    end else begin
      cpu_we = we; cpu_addr = addr; cpu_wdata = wd; cpu_req = 1'b1;
    end
    stall_n = 0; preq_n = 0; latch_ok = 1'b1; hung = 1'b1; rd = '0; err = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (p_req) begin
        preq_n++;
        if (p_we !== we || p_addr !== addr || p_wdata !== wd) latch_ok = 1'b0;
      end
      done = is_dbg ? (dbg_ack === 1'b1) : (cpu_stall === 1'b0);
      if (done) begin
        rd = is_dbg ? dbg_rdata : cpu_rdata;
        err = bus_err;
        hung = 1'b0;
        @(posedge clk); #1;
        break;
      end
      stall_n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (p_req !== 1'b0 || p_we !== 1'b0 || p_addr !== '0 || p_wdata !== '0 ||
        dbg_ack !== 1'b0 || bus_err !== 1'b0 || cpu_rdata !== '0 || dbg_rdata !== '0) begin
      miscompares++;
      $display("FAIL reset_values: p_req=%b p_we=%b p_addr=%h p_wdata=%h dbg_ack=%b bus_err=%b rdata=%h/%h, expected all zero",
               p_req, p_we, p_addr, p_wdata, dbg_ack, bus_err, cpu_rdata, dbg_rdata);
    end
    vectors++;
    if (cpu_stall !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_stall_hi: cpu_stall=%b expected 1", cpu_stall);
    end
    cpu_req = 1'b0;
    #1;
    vectors++;
    if (cpu_stall !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_stall_lo: cpu_stall=%b expected 0", cpu_stall);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    m_rdata = '0; m_last = 1;
  endtask

  task automatic test_cpu_read();
    int s, pr; logic [DW-1:0] rd; logic e; bit lok, hung;
    run_txn(1'b0, 1'b0, 32'h8000_0010, 32'h0, 0, 32'h1234_5678, s, pr, rd, e, lok, hung);
    cpu_req = 1'b0;
    m_rdata = 32'h1234_5678; m_last = 0;
    vectors++;
    if (hung || s != 2 || pr != 1) begin
      miscompares++;
      $display("FAIL cpu_read_timing: stall=%0d p_req=%0d hung=%b, expected stall=2 p_req=1", s, pr, hung);
    end
    vectors++;
    if (rd !== 32'h1234_5678 || e !== 1'b0 || !lok) begin
      miscompares++;
      $display("FAIL cpu_read_data: rdata=%h err=%b latch_ok=%b, expected 12345678 err=0 latch_ok=1", rd, e, lok);
    end
  endtask

  // Both requesters raise together; returns who completed first and ack timing.
  task automatic run_tie(input int d, output int first, output int ack_cyc, output int acks,
                         output bit hung);
    bit cfin, dfin;
    ack_delay = d;
    ack_rdata = DW'($urandom);
    cpu_we = 1'b1; cpu_addr = AW'($urandom); cpu_wdata = DW'($urandom);
    dbg_we = 1'b1; dbg_addr = AW'($urandom); dbg_wdata = DW'($urandom);
    cpu_req = 1'b1; dbg_req = 1'b1;
    first = -1; ack_cyc = -1; acks = 0; cfin = 1'b0; dfin = 1'b0; hung = 1'b1;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (cpu_req && !cpu_stall && !cfin) begin
        cfin = 1'b1;
        if (first < 0) first = 0;
      end
      if (dbg_ack === 1'b1) begin
        acks++;
        dfin = 1'b1;
        if (ack_cyc < 0) ack_cyc = c;
        if (first < 0) first = 1;
      end
      @(posedge clk); #1;
      if (cfin) cpu_req = 1'b0;
      if (dfin) dbg_req = 1'b0;
      if (cfin && dfin) begin
        hung = 1'b0;
        break;
      end
    end
    repeat (3) begin
      @(negedge clk);
      if (dbg_ack === 1'b1) acks++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_tie();
    int first, ack_cyc, acks; bit hung;
    do_reset();
    run_tie(0, first, ack_cyc, acks, hung);
    m_last = 1;
    vectors++;
    if (hung || first != 0) begin
      miscompares++;
      $display("FAIL tie_first: first=%0d hung=%b, expected CPU(0)", first, hung);
    end
    vectors++;
    if (ack_cyc != 5 || acks != 1) begin
      miscompares++;
      $display("FAIL tie_dbg_ack: ack_cycle=%0d acks=%0d, expected cycle 5 and 1 ack", ack_cyc, acks);
    end
  endtask

  task automatic test_dbg_write();
    int s, pr; logic [DW-1:0] rd; logic e; bit lok, hung;
    run_txn(1'b1, 1'b1, 32'h8000_0004, 32'h0000_00A5, 3, 32'hDEAD_BEEF, s, pr, rd, e, lok, hung);
    dbg_req = 1'b0;
    m_last = 1;
    vectors++;
    if (hung || pr != 4 || s != 5 || !lok) begin
      miscompares++;
      $display("FAIL dbg_write_timing: p_req=%0d wait=%0d latch_ok=%b hung=%b, expected 4/5/1/0", pr, s, lok, hung);
    end
    vectors++;
    if (rd !== m_rdata || e !== 1'b0) begin
      miscompares++;
      $display("FAIL dbg_write_rdata: rdata=%h err=%b, expected %h err=0", rd, e, m_rdata);
    end
  endtask

  task automatic test_timeout();
    int s, pr; logic [DW-1:0] rd; logic e; bit lok, hung;
    run_txn(1'b0, 1'b0, 32'h8000_0020, 32'h0, -1, 32'h0, s, pr, rd, e, lok, hung);
    cpu_req = 1'b0;
    m_rdata = '1; m_last = 0;
    vectors++;
    if (hung || pr != TMO || s != TMO + 1) begin
      miscompares++;
      $display("FAIL timeout_timing: p_req=%0d stall=%0d hung=%b, expected %0d/%0d", pr, s, hung, TMO, TMO + 1);
    end
    vectors++;
    if (rd !== 32'hFFFF_FFFF || e !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_data: rdata=%h err=%b, expected ffffffff err=1", rd, e);
    end
    @(negedge clk);
    vectors++;
    if (bus_err !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_pulse: bus_err=%b one cycle after done, expected 0", bus_err);
    end
    @(posedge clk); #1;
    // Ack arriving on the terminal-count cycle is a success.
    run_txn(1'b0, 1'b0, 32'h8000_0024, 32'h0, TMO - 1, 32'h0BAD_F00D, s, pr, rd, e, lok, hung);
    cpu_req = 1'b0;
    m_rdata = 32'h0BAD_F00D;
    vectors++;
    if (hung || pr != TMO || rd !== 32'h0BAD_F00D || e !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_edge_ack: p_req=%0d rdata=%h err=%b, expected %0d 0badf00d 0", pr, rd, e, TMO);
    end
  endtask

  task automatic test_reset_mid();
    bit bad;
    ack_delay = -1;
    dbg_we = 1'b0; dbg_addr = 32'h8000_0100; dbg_req = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    dbg_req = 1'b0;
    cpu_we = 1'b0; cpu_addr = 32'h8000_0200; cpu_req = 1'b1;
    ack_delay = 0; ack_rdata = 32'h5566_7788;
    #1;
    vectors++;
    if (p_req !== 1'b0 || cpu_stall !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_mid_immediate: p_req=%b cpu_stall=%b, expected 0/1", p_req, cpu_stall);
    end
    bad = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (dbg_ack !== 1'b0 || bus_err !== 1'b0 || p_req !== 1'b0) bad = 1'b1;
    end
    vectors++;
    if (bad) begin
      miscompares++;
      $display("FAIL reset_mid_quiet: completion or p_req seen during reset, expected none");
    end
    @(posedge clk); #1 rst_n = 1'b1;
    m_rdata = '0; m_last = 1;
    @(negedge clk);
    vectors++;
    if (p_req !== 1'b0 || cpu_rdata !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_idle: p_req=%b rdata=%h, expected 0/0", p_req, cpu_rdata);
    end
    @(posedge clk); #1;
    @(negedge clk);
    vectors++;
    if (p_req !== 1'b1 || p_addr !== 32'h8000_0200) begin
      miscompares++;
      $display("FAIL reset_mid_grant: p_req=%b p_addr=%h, expected 1/80000200", p_req, p_addr);
    end
    @(posedge clk); #1;
    @(negedge clk);
    vectors++;
    if (cpu_stall !== 1'b0 || cpu_rdata !== 32'h5566_7788) begin
      miscompares++;
      $display("FAIL reset_mid_done: stall=%b rdata=%h, expected 0/55667788", cpu_stall, cpu_rdata);
    end
    @(posedge clk); #1;
    cpu_req = 1'b0;
    m_rdata = 32'h5566_7788; m_last = 0;
  endtask

  task automatic test_back_to_back();
    int s, pr; logic [DW-1:0] rd, rv; logic e; bit lok, hung;
    for (int i = 0; i < 4; i++) begin
      rv = DW'($urandom);
      run_txn(1'b0, 1'b0, AW'($urandom), DW'($urandom), 0, rv, s, pr, rd, e, lok, hung);
      vectors++;
      if (hung || s != 2 || rd !== rv || !lok) begin
        miscompares++;
        $display("FAIL back_to_back[%0d]: stall=%0d rdata=%h latch_ok=%b, expected 2 %h 1", i, s, rd, lok, rv);
      end
    end
    cpu_req = 1'b0;
    m_rdata = rv; m_last = 0;
  endtask

  task automatic test_random();
    int s, pr, d, mode, first, ack_cyc, acks, exp_first;
    logic [DW-1:0] rd, rv, er; logic e; bit lok, hung, we, isd;
    logic [AW-1:0] a; logic [DW-1:0] wd;
    noise_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      mode = $urandom_range(0, 2);
      d = $urandom_range(0, 4) == 0 ? -1 : $urandom_range(0, TMO + 2);
      if (mode < 2) begin
        isd = (mode == 1);
        we = 1'($urandom_range(0, 1));
        a = AW'($urandom); wd = DW'($urandom); rv = DW'($urandom);
        er = exp_rdata(m_rdata, we, d, rv);
        run_txn(isd, we, a, wd, d, rv, s, pr, rd, e, lok, hung);
        if (isd) dbg_req = 1'b0; else cpu_req = 1'b0;
        vectors++;
        if (hung || pr != exp_preq(d) || s != exp_preq(d) + 1 || !lok) begin
          miscompares++;
          $display("FAIL rand_timing[%0d]: dbg=%b d=%0d p_req=%0d stall=%0d latch_ok=%b, expected %0d/%0d/1",
                   i, isd, d, pr, s, lok, exp_preq(d), exp_preq(d) + 1);
        end
        vectors++;
        if (rd !== er || e !== exp_err(d)) begin
          miscompares++;
          $display("FAIL rand_data[%0d]: rdata=%h err=%b, expected %h %b", i, rd, e, er, exp_err(d));
        end
        m_rdata = er;
        m_last = isd ? 1 : 0;
      end else begin
        exp_first = (m_last == 1) ? 0 : 1;
        run_tie($urandom_range(0, 3), first, ack_cyc, acks, hung);
        vectors++;
        if (hung || first != exp_first || acks != 1) begin
          miscompares++;
          $display("FAIL rand_tie[%0d]: first=%0d acks=%0d hung=%b, expected first=%0d acks=1",
                   i, first, acks, hung, exp_first);
        end
        m_last = 1 - exp_first;
      end
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    noise_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_tie();
    test_dbg_write();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
